// File: rtl/simon_key_expand.sv
// Simon key-schedule engine: latches an M-word master key on start and streams round keys 0..T-1.
// Latency: first key valid the cycle after start is sampled; one key per cycle after that.
// Backpressure: rk_valid/rk_ready handshake; window, rk_data and rk_idx hold while rk_ready is low.
//
// Parameters: N word width, M key words, T rounds, ZSEL z-sequence (0..4), IW = $clog2(T).
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, key_in       start request (accepted only in IDLE) and master key, k[0] in the low word
//   busy, done          busy while streaming; done pulses the cycle after the last key is accepted
//   rk_valid, rk_ready  round-key handshake
//   rk_data, rk_idx     current round key and its index
//   rd_addr, rd_data    round-key store read port, 1-cycle latency (only with SIMON_KEY_STORE_EN)
// Optional feature macro: SIMON_KEY_STORE_EN adds a T x N round-key store with a registered read port.
module simon_key_expand #(
    parameter int  N    = 16,
    parameter int  M    = 4,
    parameter int  T    = 32,
    parameter int  ZSEL = 0,
    localparam int IW   = $clog2(T)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*M-1:0]  key_in,
    output logic            busy,
    output logic            done,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [N-1:0]    rk_data,
    output logic [IW-1:0]   rk_idx
`ifdef SIMON_KEY_STORE_EN
    ,
    input  logic [IW-1:0]   rd_addr,
    output logic [N-1:0]    rd_data
`endif
);

    // Published z sequences written as text; character i (leftmost = 0) is bit 61-i.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] Z_SEQ = (ZSEL == 0) ? Z0 :
                                    (ZSEL == 1) ? Z1 :
                                    (ZSEL == 2) ? Z2 :
                                    (ZSEL == 3) ? Z3 : Z4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic [IW-1:0]   rk_idx_q;
    logic [5:0]      zi_q;
    logic [N-1:0]    w_q [M];

    logic            hs;
    logic            z_bit;
    logic [N-1:0]    tmp;
    logic [N-1:0]    w_new_d;

    assign hs = valid_q & rk_ready;

    // Next key word from the pre-shift window: w[0] is k[i-M], w[M-1] is k[i-1], w[1] is k[i-3] when M==4.
    always_comb begin
        z_bit = Z_SEQ[6'd61 - zi_q];
        tmp   = {w_q[M-1][2:0], w_q[M-1][N-1:3]};
        if (M == 4) begin
            tmp = tmp ^ w_q[1];
        end
        tmp     = tmp ^ {tmp[0], tmp[N-1:1]};
        // ~k ^ 3 folded into one constant: all ones except the two low bits.
        w_new_d = w_q[0] ^ tmp ^ ({N{1'b1}} << 2) ^ {{(N-1){1'b0}}, z_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            rk_idx_q <= '0;
            zi_q     <= '0;
            for (int j = 0; j < M; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int j = 0; j < M; j++) begin
                            w_q[j] <= key_in[N*j +: N];
                        end
                        rk_idx_q <= '0;
                        zi_q     <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        for (int j = 0; j < M-1; j++) begin
                            w_q[j] <= w_q[j+1];
                        end
                        w_q[M-1] <= w_new_d;
                        rk_idx_q <= rk_idx_q + IW'(1);
                        // zi is the z position of key rk_idx+M, the one being generated, so it
                        // advances on every handshake and wraps at the 62-bit sequence length.
                        zi_q     <= (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
                        if (rk_idx_q == IW'(T-1)) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rk_valid = valid_q;
    assign rk_data  = w_q[0];
    assign rk_idx   = rk_idx_q;

`ifdef SIMON_KEY_STORE_EN
    // Store holds the keys of the latest run; no reset so it can map onto plain register/RAM cells.
    // Reading the entry being written this cycle returns its previous contents.
    logic [N-1:0] store_q [T];
    logic [N-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (hs) begin
            store_q[rk_idx_q] <= w_q[0];
        end
        if (int'(rd_addr) < T) begin
            rd_data_q <= store_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;
`else
    // Streaming-only build: no round-key store and no read port.
`endif

endmodule

// File: tb/tb_simon_key_expand.sv
module tb_simon_key_expand;

    localparam int NA = 16, MA = 4, TA = 32, ZA = 0, IWA = $clog2(TA);
    localparam int NB = 64, MB = 2, TB = 68, ZB = 2, IWB = $clog2(TB);
    localparam logic [63:0] K0 = 64'h1918_1110_0908_0100;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT A: Simon32/64 defaults
    logic             rst_a, start_a, busy_a, done_a, rk_valid_a, rk_ready_a;
    logic [NA*MA-1:0] key_in_a;
    logic [NA-1:0]    rk_data_a;
    logic [IWA-1:0]   rk_idx_a;
    // DUT B: Simon128/128
    logic             rst_b, start_b, busy_b, done_b, rk_valid_b, rk_ready_b;
    logic [NB*MB-1:0] key_in_b;
    logic [NB-1:0]    rk_data_b;
    logic [IWB-1:0]   rk_idx_b;
`ifdef SIMON_KEY_STORE_EN
    logic [IWA-1:0]   rd_addr_a;
    logic [NA-1:0]    rd_data_a;
    logic [IWB-1:0]   rd_addr_b;
    logic [NB-1:0]    rd_data_b;
`endif

    simon_key_expand #(.N(NA), .M(MA), .T(TA), .ZSEL(ZA)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .key_in(key_in_a),
        .busy(busy_a), .done(done_a), .rk_valid(rk_valid_a), .rk_ready(rk_ready_a),
        .rk_data(rk_data_a), .rk_idx(rk_idx_a)
`ifdef SIMON_KEY_STORE_EN
        , .rd_addr(rd_addr_a), .rd_data(rd_data_a)
`endif
    );

    simon_key_expand #(.N(NB), .M(MB), .T(TB), .ZSEL(ZB)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .key_in(key_in_b),
        .busy(busy_b), .done(done_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready_b),
        .rk_data(rk_data_b), .rk_idx(rk_idx_b)
`ifdef SIMON_KEY_STORE_EN
        , .rd_addr(rd_addr_b), .rd_data(rd_data_b)
`endif
    );

    typedef struct {
        int          idx;
        logic [63:0] dat;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] gk [72];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic zbit(input int zsel, input int i);
        logic [61:0] z;
        case (zsel)
            0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
            1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
            default: z = 62'b11010001111001101011011000100000010111000011001010010011101111;
        endcase
        return z[61-i];
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n,
                                        input logic [63:0] mask);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    // Reference key schedule in the classic array form: k[i] = ~k[i-m] ^ tmp ^ z ^ 3.
    task automatic build_gold(input int n, input int m, input int t, input int zsel,
                              input logic [255:0] key);
        logic [63:0]  mask;
        logic [63:0]  tmp;
        logic [255:0] sh;
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) begin
            sh    = key >> (n * i);
            gk[i] = sh[63:0] & mask;
        end
        for (int i = m; i < t; i++) begin
            tmp = ror(gk[i-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ gk[i-3];
            tmp   = tmp ^ ror(tmp, 1, n, mask);
            gk[i] = (~gk[i-m] & mask) ^ tmp ^ 64'(zbit(zsel, (i - m) % 62)) ^ 64'd3;
        end
    endtask

    function automatic logic [63:0] hand_a(input int i);
        case (i)
            0:       return 64'h0100;
            1:       return 64'h0908;
            2:       return 64'h1110;
            3:       return 64'h1918;
            default: return 64'h71C3;
        endcase
    endfunction

    // Monitor A: pops the scoreboard on each handshake, checks stall stability and the done pulse.
    logic           exp_done_a = 1'b0;
    logic           prev_stall_a = 1'b0;
    logic [NA-1:0]  prev_dat_a;
    logic [IWA-1:0] prev_idx_a;
    exp_t           ea;
    always @(negedge clk) begin
        if (rst_a) begin
            exp_done_a   = 1'b0;
            prev_stall_a = 1'b0;
        end else begin
            chk("done_a", 64'(done_a), 64'(exp_done_a));
            if (exp_done_a) chk("busy_in_done_a", 64'(busy_a), 64'd0);
            if (prev_stall_a) begin
                chk("stall_valid_a", 64'(rk_valid_a), 64'd1);
                chk("stall_data_a", 64'(rk_data_a), 64'(prev_dat_a));
                chk("stall_idx_a", 64'(rk_idx_a), 64'(prev_idx_a));
            end
            exp_done_a = 1'b0;
            if (rk_valid_a && rk_ready_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_a: idx %0d data %h with empty scoreboard", rk_idx_a, rk_data_a);
                end else begin
                    ea = qa.pop_front();
                    chk("key_idx_a", 64'(rk_idx_a), 64'(ea.idx));
                    chk("key_data_a", 64'(rk_data_a), ea.dat);
                    if (ea.idx == TA - 1) exp_done_a = 1'b1;
                end
            end
            prev_stall_a = rk_valid_a && !rk_ready_a;
            prev_dat_a   = rk_data_a;
            prev_idx_a   = rk_idx_a;
        end
    end

    logic exp_done_b = 1'b0;
    exp_t eb;
    always @(negedge clk) begin
        if (rst_b) begin
            exp_done_b = 1'b0;
        end else begin
            chk("done_b", 64'(done_b), 64'(exp_done_b));
            exp_done_b = 1'b0;
            if (rk_valid_b && rk_ready_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_b: idx %0d data %h with empty scoreboard", rk_idx_b, rk_data_b);
                end else begin
                    eb = qb.pop_front();
                    chk("key_idx_b", 64'(rk_idx_b), 64'(eb.idx));
                    chk("key_data_b", rk_data_b, eb.dat);
                    if (eb.idx == TB - 1) exp_done_b = 1'b1;
                end
            end
        end
    end

    // One run on DUT A. rst_at >= 0 resets the block when that index is on the port.
    task automatic run_a(input logic [63:0] key, input bit rand_rdy, input bit inject,
                         input int rst_at, output int cycles);
        int  c0;
        bit  seen;
        exp_t e;
        build_gold(NA, MA, TA, ZA, {192'd0, key});
        for (int i = 0; i < TA; i++) begin
            e.idx = i;
            e.dat = (key == K0 && i < 5) ? hand_a(i) : gk[i];
            qa.push_back(e);
        end
        cycles = -1;
        @(posedge clk); #1;
        key_in_a   = key;
        start_a    = 1'b1;
        c0         = cyc;
        rk_ready_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_a  = 1'b0;
        key_in_a = ~key;
        seen     = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            if (rst_at >= 0 && rk_valid_a && int'(rk_idx_a) == rst_at) begin
                rst_a      = 1'b1;
                rk_ready_a = 1'b0;
                @(posedge clk); #1;
                rst_a = 1'b0;
                chk("rst_busy", 64'(busy_a), 64'd0);
                chk("rst_done", 64'(done_a), 64'd0);
                chk("rst_valid", 64'(rk_valid_a), 64'd0);
                chk("rst_data", 64'(rk_data_a), 64'd0);
                chk("rst_idx", 64'(rk_idx_a), 64'd0);
                qa.delete();
                @(posedge clk); #1;
                chk("rst_idle_valid", 64'(rk_valid_a), 64'd0);
                chk("rst_idle_busy", 64'(busy_a), 64'd0);
                rk_ready_a = 1'b1;
                return;
            end
            rk_ready_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start_a    = inject && (c == 5);
            if (start_a) key_in_a = 64'hDEAD_BEEF_CAFE_F00D;
            @(negedge clk);
            if (done_a) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (seen) begin
            cycles = cyc - c0;
            if (inject) begin
                start_a  = 1'b1;
                key_in_a = 64'h0F0F_F0F0_1234_5678;
                @(posedge clk); #1;
                start_a = 1'b0;
                @(negedge clk);
                chk("start_in_done_valid", 64'(rk_valid_a), 64'd0);
                chk("start_in_done_busy", 64'(busy_a), 64'd0);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL timeout_a: no done within 600 cycles, %0d keys outstanding", qa.size());
        end
        chk("queue_drained_a", 64'(qa.size()), 64'd0);
        rk_ready_a = 1'b1;
    endtask

    task automatic run_b(input logic [127:0] key, output int cycles);
        int  c0;
        bit  seen;
        exp_t e;
        build_gold(NB, MB, TB, ZB, {128'd0, key});
        for (int i = 0; i < TB; i++) begin
            e.idx = i;
            e.dat = gk[i];
            qb.push_back(e);
        end
        cycles = -1;
        @(posedge clk); #1;
        key_in_b = key;
        start_b  = 1'b1;
        c0       = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        if (seen) cycles = cyc - c0;
        else begin
            checks++;
            errors++;
            $display("FAIL timeout_b: no done within 400 cycles, %0d keys outstanding", qb.size());
        end
        chk("queue_drained_b", 64'(qb.size()), 64'd0);
    endtask

    int          ncyc;
    logic [63:0] last_a;

    initial begin
        rst_a = 1'b1; start_a = 1'b0; key_in_a = '0; rk_ready_a = 1'b1;
        rst_b = 1'b1; start_b = 1'b0; key_in_b = '0; rk_ready_b = 1'b1;
`ifdef SIMON_KEY_STORE_EN
        rd_addr_a = '0;
        rd_addr_b = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_done", 64'(done_a), 64'd0);
        chk("reset_valid", 64'(rk_valid_a), 64'd0);
        chk("reset_data", 64'(rk_data_a), 64'd0);
        chk("reset_idx", 64'(rk_idx_a), 64'd0);
        chk("reset_valid_b", 64'(rk_valid_b), 64'd0);

        // Full-rate stream with the published Simon32/64 key
        run_a(K0, 1'b0, 1'b0, -1, ncyc);
        chk("stream_cycles", 64'(ncyc), 64'd33);
        last_a = gk[TA-1];
`ifdef SIMON_KEY_STORE_EN
        @(posedge clk); #1;
        rd_addr_a = 5'd4;
        @(posedge clk); #1;
        chk("store_rd4", 64'(rd_data_a), 64'h71C3);
        rd_addr_a = 5'd31;
        @(posedge clk); #1;
        chk("store_rd31", 64'(rd_data_a), last_a);
`endif

        // Random backpressure, same key and sequence
        run_a(K0, 1'b1, 1'b0, -1, ncyc);

        // start pulsed in RUN and in DONE is ignored
        run_a(K0, 1'b0, 1'b1, -1, ncyc);
        chk("inject_cycles", 64'(ncyc), 64'd33);

        // Reset mid-stream, then a clean run with another key
        run_a(K0, 1'b0, 1'b0, 10, ncyc);
        run_a(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, -1, ncyc);
        chk("after_rst_cycles", 64'(ncyc), 64'd33);

        // Simon128/128: z index wraps at key 64
        run_b({$urandom, $urandom, $urandom, $urandom}, ncyc);
        chk("stream_cycles_b", 64'(ncyc), 64'(TB + 1));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
